// File: rtl/control_splitter.sv
// control_splitter: snapshots a LANES x WIDTH parameter vector on capture and
// streams it back one word per read strobe, lane 0 first, for pipe readback.
module control_splitter #(
  parameter int LANES = 64,
  parameter int WIDTH = 16,
  parameter int ADDRW = 6
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [LANES*WIDTH-1:0] combinedin,
  input  logic                   capture,
  input  logic                   read,
  output logic [WIDTH-1:0]       dataout,
  output logic [ADDRW-1:0]       blockaddress,
  output logic                   busy,
  output logic                   done,
  output logic                   underrun,
  output logic [ADDRW:0]         wordsleft
);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } state_t;

  localparam logic [ADDRW-1:0] LAST_ADDR = ADDRW'(LANES - 1);
  localparam logic [ADDRW-1:0] ONE_ADDR  = ADDRW'(1);
  localparam logic [ADDRW:0]   LANES_W   = (ADDRW + 1)'(LANES);
  localparam logic [ADDRW:0]   ONE_LEFT  = (ADDRW + 1)'(1);

  state_t               state_r;
  state_t               state_nxt_s;
  logic [WIDTH-1:0]     shadow_r [LANES];
  logic [WIDTH-1:0]     dataout_r;
  logic [WIDTH-1:0]     dataout_nxt_s;
  logic [ADDRW-1:0]     addr_r;
  logic [ADDRW-1:0]     addr_nxt_s;
  logic [ADDRW-1:0]     next_addr_s;
  logic [ADDRW:0]       left_r;
  logic [ADDRW:0]       left_nxt_s;
  logic                 busy_r;
  logic                 done_r;
  logic                 done_nxt_s;
  logic                 underrun_r;
  logic                 underrun_nxt_s;

  assign next_addr_s  = addr_r + ONE_ADDR;

  assign dataout      = dataout_r;
  assign blockaddress = addr_r;
  assign busy         = busy_r;
  assign done         = done_r;
  assign underrun     = underrun_r;
  assign wordsleft    = left_r;

  // Shadow snapshot: loaded only on capture so later source changes never leak into a stream.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < LANES; k++) begin
        shadow_r[k] <= '0;
      end
    end else if (capture) begin
      for (int k = 0; k < LANES; k++) begin
        shadow_r[k] <= combinedin[k*WIDTH +: WIDTH];
      end
    end
  end

  // Next-state and next-output decode; capture outranks read, read in IDLE flags underrun.
  always_comb begin
    state_nxt_s    = state_r;
    dataout_nxt_s  = dataout_r;
    addr_nxt_s     = addr_r;
    left_nxt_s     = left_r;
    underrun_nxt_s = underrun_r;
    done_nxt_s     = 1'b0;
    if (capture) begin
      state_nxt_s    = ST_STREAM;
      dataout_nxt_s  = combinedin[WIDTH-1:0];
      addr_nxt_s     = '0;
      left_nxt_s     = LANES_W;
      underrun_nxt_s = 1'b0;
    end else if (read) begin
      case (state_r)
        ST_STREAM: begin
          if (addr_r == LAST_ADDR) begin
            // Final word consumed: return to idle and pulse done once.
            state_nxt_s   = ST_IDLE;
            dataout_nxt_s = '0;
            addr_nxt_s    = '0;
            left_nxt_s    = '0;
            done_nxt_s    = 1'b1;
          end else begin
            addr_nxt_s    = next_addr_s;
            dataout_nxt_s = shadow_r[next_addr_s];
            left_nxt_s    = left_r - ONE_LEFT;
          end
        end
        ST_IDLE: begin
          underrun_nxt_s = 1'b1;
        end
        default: begin
          state_nxt_s   = ST_IDLE;
          dataout_nxt_s = '0;
          addr_nxt_s    = '0;
          left_nxt_s    = '0;
        end
      endcase
    end else begin
      // No strobe: everything holds, so a stream may stall indefinitely.
      state_nxt_s = state_r;
    end
  end

  // State and output registers; reset abandons any stream without a done pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r    <= ST_IDLE;
      dataout_r  <= '0;
      addr_r     <= '0;
      left_r     <= '0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      underrun_r <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      dataout_r  <= dataout_nxt_s;
      addr_r     <= addr_nxt_s;
      left_r     <= left_nxt_s;
      busy_r     <= (state_nxt_s == ST_STREAM);
      done_r     <= done_nxt_s;
      underrun_r <= underrun_nxt_s;
    end
  end

endmodule

// File: doc/control_splitter.md
Name: control_splitter

Overview:
- Read-side counterpart of controlcombiner.
- On a capture strobe, snapshots a wide LANES×WIDTH parameter vector (e.g. activeamps / activeoffsets / activephasewords) into a shadow register.
- Streams the snapshot out one WIDTH-bit word per read strobe, lane 0 first, for readback through an okPipeOut-style ep_read / ep_datain interface.
- Sits in the ti_clk domain between the parameter registers and the readback pipe endpoint.

Parameters:
- LANES, 64, number of words in the wide vector.
- WIDTH, 16, bits per word.
- ADDRW, 6, index width; must satisfy 2**ADDRW >= LANES.

Ports:
- clk  input  1  single clock; all logic on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- combinedin  input  LANES*WIDTH  wide source vector; lane k occupies bits [k*WIDTH +: WIDTH].
- capture  input  1  single-cycle strobe: latch combinedin and start a stream.
- read  input  1  consume current dataout word, advance to next.
- dataout  output  WIDTH  current word (registered).
- blockaddress  output  ADDRW  index of the word currently on dataout.
- busy  output  1  high while in STREAM.
- done  output  1  one-cycle pulse after the final word is consumed.
- underrun  output  1  sticky; read seen while not in STREAM.
- wordsleft  output  ADDRW+1  words not yet consumed: LANES-blockaddress in STREAM, 0 in IDLE.

Behaviour:
- Reset (reset_n low, async):
  - state=IDLE; shadow=0; dataout=0; blockaddress=0.
  - busy=0, done=0, underrun=0, wordsleft=0.
  - Takes effect immediately, including mid-stream; the stream is abandoned and no done pulse is generated.
- States: IDLE, STREAM. busy = (state==STREAM), registered.
- done defaults to 0 every cycle; asserted only as below.
- capture (any state, highest priority):
  - shadow<=combinedin; blockaddress<=0; dataout<=combinedin[WIDTH-1:0].
  - underrun<=0; state<=STREAM; wordsleft<=LANES.
  - Latency: word 0 valid on dataout the cycle after the capture edge.
  - capture during STREAM restarts from lane 0 with the new snapshot; no done for the aborted stream.
  - capture and read in the same cycle: capture wins, read is discarded (not counted, no underrun).
- read in STREAM with blockaddress < LANES-1:
  - blockaddress<=blockaddress+1; dataout<=shadow[(blockaddress+1)*WIDTH +: WIDTH]; wordsleft<=wordsleft-1.
  - Next word appears the cycle after the read edge.
  - Back-to-back reads every cycle are supported at full rate.
- read in STREAM with blockaddress == LANES-1 (final word):
  - state<=IDLE; dataout<=0; blockaddress<=0; wordsleft<=0; done<=1 for exactly one cycle.
- read in IDLE: underrun<=1 (sticky until capture or reset); dataout, blockaddress, wordsleft unchanged (0).
- No read in STREAM: all outputs hold; a stream may stall indefinitely.
- combinedin changes after capture: no effect; only shadow is streamed.
- No wrap-around: blockaddress never exceeds LANES-1; it never increments past the final word.
- Word order is the inverse of controlcombiner: a vector built by writing words w0..w(LANES-1) at blockaddress 0..LANES-1 streams back as w0..w(LANES-1).

Test Plan:
- Reset then idle: reset_n low 3 cycles, release -> all outputs 0; busy=0; wordsleft=0.
- Full stream: combinedin lane k = 16'h1000+k; pulse capture; assert read for 64 consecutive cycles -> dataout sequence 16'h1000..16'h103F, one per cycle starting one cycle after capture; blockaddress 0..63; done high exactly one cycle after the 64th read; busy falls with done; dataout=0 afterwards.
- Stall and snapshot isolation: capture lane0=16'hAAAA, lane1=16'h5555; change combinedin to all-ones; read once, idle 10 cycles -> dataout holds 16'h5555, wordsleft=63, busy=1 throughout.
- Restart mid-stream: after 20 reads, capture with lane k = 16'hB000+k, read asserted in the same cycle -> next cycle blockaddress=0, dataout=16'hB000, wordsleft=64, no done pulse, read not counted.
- Underrun: in IDLE assert read 2 cycles -> underrun=1 and stays 1; dataout=0; subsequent capture clears underrun the following cycle.
- Async reset mid-stream: after 30 reads, drop reset_n between clock edges -> outputs 0 immediately without a clock edge; no done pulse; after release, read sets underrun.
